instr_ram_arbiter: RTL and testbench
====================================

Name: instr_ram_arbiter

Overview:
- Shares the single-port instruction RAM between two requesters: the CPU instruction-fetch port (read-only) and the debug/loader port (read/write with byte enables).
- Sits between the fetch stage/debug loader and the instruction RAM.
- Fetch has default priority. A starvation counter forces a debug grant after a bounded wait.
- Tracks the RAM's 1-cycle read latency and routes returned data to the correct requester.

Parameters:
- ADDR_W, 12, word-address width (matches RAM addra).
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, consecutive denied debug-request cycles before debug gets priority. Legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held until granted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dbg_req  in  1  debug request; held with stable fields until granted
- dbg_we  in  4  byte write enables; 4'b0000 means read
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug request accepted this cycle (combinational)
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- ram_wea  out  4  to RAM wea
- ram_addra  out  ADDR_W  to RAM addra
- ram_dina  out  DATA_W  to RAM dina
- ram_douta  in  DATA_W  from RAM douta (registered, 1-cycle latency)

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high; all state updates on posedge clk.
- Reset values:
  - state = PRIO_IF, starve_cnt = 0.
  - if_rvalid = 0, dbg_rvalid = 0.
  - if_gnt and dbg_gnt forced to 0 while rst = 1.
  - ram_wea = 0 while rst = 1.
- FSM states:
  - PRIO_IF: fetch wins when both request.
  - PRIO_DBG: debug wins when both request.
- Transitions:
  - PRIO_IF -> PRIO_DBG when dbg_req && !dbg_gnt && starve_cnt == STARVE_LIMIT-1 (the denial that reaches the limit).
  - PRIO_DBG -> PRIO_IF on the cycle dbg_gnt = 1.
  - PRIO_DBG -> PRIO_IF if dbg_req drops.
- Grant rules (combinational, same cycle as request):
  - Exactly one or zero grants per cycle.
  - A sole requester is always granted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or dbg_req=0.
- RAM drive:
  - Granted requester's address goes to ram_addra.
  - ram_wea = dbg_we only when dbg_gnt, otherwise 0.
  - ram_dina = dbg_wdata.
  - With no grant: ram_addra = if_addr, ram_wea = 0.
- Read return:
  - Registered owner tag: 00 none, 01 fetch read, 10 debug read. Captured at grant.
  - Debug writes set tag to none.
  - Next cycle, if_rvalid = (tag==01) and dbg_rvalid = (tag==10).
  - if_rdata and dbg_rdata are both driven from ram_douta, qualified by rvalid.
  - Latency grant -> rvalid = exactly 1 cycle.
  - Back-to-back grants give one rvalid per cycle, in grant order.
- Write then read of the same address on consecutive cycles returns the new data (RAM write in cycle N is visible to a read issued in N+1).
- Debug writes produce no rvalid; dbg_gnt is the write acknowledgement.
- Reset mid-operation: a read granted in the cycle rst rises gets no rvalid. FSM and counter return to reset values.
- Requester deasserting req before grant is legal; nothing is issued for it.

Test Plan:
- Fetch only: if_req=1, if_addr=0..3 over 4 cycles with RAM preloaded (word0=32'h00504713) -> if_gnt=1 each cycle; if_rvalid pulses cycles 1..4; if_rdata cycle 1 = 32'h00504713.
- Debug write then fetch read: dbg_we=4'hF, addr=5, wdata=32'hDEADBEEF granted in cycle N; if_req addr=5 in N+1 -> if_rdata=32'hDEADBEEF in N+2; dbg_rvalid stays 0.
- Byte-enable write: dbg_we=4'b0011, wdata=32'h12345678 to a word holding 32'hAAAAAAAA; debug read back -> dbg_rvalid with dbg_rdata=32'hAAAA5678.
- Starvation, STARVE_LIMIT=8: if_req and dbg_req held high continuously -> dbg denied 8 cycles, dbg_gnt on the 9th with if_gnt=0, FSM back to PRIO_IF, fetch granted on the 10th.
- Simultaneous requests, counter below limit: both requests high for 1 cycle -> if_gnt=1, dbg_gnt=0, starve_cnt=1. Then dbg_req drops -> starve_cnt=0.
- Reset mid-read: fetch granted, rst=1 next cycle -> if_rvalid=0, gnts 0, ram_wea=0. After rst falls, the first fetch behaves as after a cold reset.

Source files
------------

// File: rtl/instr_ram_arbiter.sv
// instr_ram_arbiter: shares the single-port instruction RAM between the
// fetch port (read-only) and the debug/loader port (read/write, byte
// enables). Fetch wins by default; a debug starvation counter flips the
// priority after a bounded number of denied cycles. Read data returns one
// cycle after grant and is routed using a registered owner tag.
module instr_ram_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dbg_req,
  input  logic [3:0]        dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  // Counter is sized for the largest legal limit (255).
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    PRIO_IF  = 1'b0,
    PRIO_DBG = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_IF   = 2'b01,
    TAG_DBG  = 2'b10
  } tag_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  tag_t             tag;
  logic             dbg_denied;

  // A debug request that is present but not served this cycle.
  assign dbg_denied = dbg_req && !dbg_gnt;

  // Same-cycle grant: sole requester always wins, priority breaks ties.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state == PRIO_DBG) begin
        dbg_gnt = dbg_req;
        if_gnt  = if_req && !dbg_req;
      end else begin
        if_gnt  = if_req;
        dbg_gnt = dbg_req && !if_req;
      end
    end
  end

  // RAM port mux: fetch address by default, writes only on a debug grant.
  always_comb begin
    ram_addra = if_addr;
    ram_wea   = 4'b0000;
    ram_dina  = dbg_wdata;
    if (dbg_gnt) begin
      ram_addra = dbg_addr;
      ram_wea   = dbg_we;
    end
  end

  // Priority FSM: debug takes priority once it has been starved long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIO_IF;
    end else begin
      case (state)
        PRIO_IF: begin
          if (dbg_denied && (starve_cnt == LIMIT_M1)) begin
            state <= PRIO_DBG;
          end
        end
        PRIO_DBG: begin
          if (dbg_gnt || !dbg_req) begin
            state <= PRIO_IF;
          end
        end
        default: state <= PRIO_IF;
      endcase
    end
  end

  // Count consecutive denied debug cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst || dbg_gnt || !dbg_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= CNT_W'(starve_cnt + 1'b1);
    end
  end

  // Owner of the read in flight; debug writes return nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= TAG_NONE;
    end else if (if_gnt) begin
      tag <= TAG_IF;
    end else if (dbg_gnt && (dbg_we == 4'b0000)) begin
      tag <= TAG_DBG;
    end else begin
      tag <= TAG_NONE;
    end
  end

  // Return path: a read in flight when reset rises is dropped.
  assign if_rvalid  = (tag == TAG_IF)  && !rst;
  assign dbg_rvalid = (tag == TAG_DBG) && !rst;
  assign if_rdata   = if_rvalid  ? ram_douta : '0;
  assign dbg_rdata  = dbg_rvalid ? ram_douta : '0;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Self-checking bench for instr_ram_arbiter with a behavioural 1-cycle RAM
// and a queue of expected read returns.
module tb_instr_ram_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dbg_req;
  logic [3:0]        dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [3:0]        ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  instr_ram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    case (i)
      0:       return 32'h00504713;
      7:       return 32'hAAAAAAAA;
      default: return 32'(i) * 32'h9E3779B1;
    endcase
  endfunction

  // Behavioural RAM: byte-enable write, registered read, preloaded once.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
      preload_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_douta <= mem[ram_addra];
  end

  // Reference memory contents and expected-return scoreboard.
  typedef struct packed {
    logic              if_v;
    logic              dbg_v;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  ret_t              exp_q [$];
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after negedge, check settled outputs,
  // then record what this cycle's grant should return next cycle.
  task automatic drive_cycle(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                             input logic dr, input logic [3:0] dwe,
                             input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd,
                             input logic exp_ig, input logic exp_dg);
    ret_t e;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia;
    dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    #1;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else if (!r) check("sb_underflow", 32'(exp_q.size()), 32'd1);
    if (r) e = '0;
    check("if_rvalid",  32'(if_rvalid),  32'(e.if_v));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(e.dbg_v));
    if (e.if_v)  check("if_rdata",  if_rdata,  e.data);
    if (e.dbg_v) check("dbg_rdata", dbg_rdata, e.data);
    check("if_gnt",    32'(if_gnt),    32'(exp_ig));
    check("dbg_gnt",   32'(dbg_gnt),   32'(exp_dg));
    check("ram_wea",   32'(ram_wea),   exp_dg ? 32'(dwe) : 32'd0);
    check("ram_addra", 32'(ram_addra), exp_dg ? 32'(da) : 32'(ia));
    e = '0;
    if (exp_ig) begin
      e.if_v = 1'b1;
      e.data = ref_mem[ia];
    end else if (exp_dg) begin
      if (dwe == 4'b0000) begin
        e.dbg_v = 1'b1;
        e.data  = ref_mem[da];
      end else begin
        for (int b = 0; b < 4; b++)
          if (dwe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    check(tag, 32'(dut.starve_cnt), exp);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dbg_req = 1'b0; dbg_we = 4'h0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);

    // Reset: no grants, no write strobes even with requests present.
    drive_cycle(1'b1, 1'b1, 12'h001, 1'b1, 4'hF, 12'h003, 32'h1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, '0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check("cnt_after_reset", 32'(dut.starve_cnt), 32'd0);
    idle();

    // Fetch-only stream of four reads, one return per cycle.
    for (int k = 0; k < 4; k++)
      drive_cycle(1'b0, 1'b1, 12'(k), 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    idle();

    // Debug write then fetch read of the same word on the next cycle.
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'hF, 12'h005, 32'hDEADBEEF, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 12'h005, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    idle();

    // Partial byte-enable write followed by a debug read-back.
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'b0011, 12'h007, 32'h12345678, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 4'b0000, 12'h007, '0, 1'b0, 1'b1);
    idle();

    // Starvation: eight denials, then debug wins, then fetch again.
    for (int k = 0; k < 8; k++)
      drive_cycle(1'b0, 1'b1, 12'(16 + k), 1'b1, 4'h0, 12'h002, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 12'h020, 1'b1, 4'h0, 12'h002, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 12'h021, 1'b1, 4'h0, 12'h002, '0, 1'b1, 1'b0);
    idle();

    // Starved debug withdraws: priority falls back to fetch.
    for (int k = 0; k < 8; k++)
      drive_cycle(1'b0, 1'b1, 12'(32 + k), 1'b1, 4'h0, 12'h003, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 12'h030, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 12'h031, 1'b1, 4'h0, 12'h003, '0, 1'b1, 1'b0);
    idle();

    // Single simultaneous request below the limit, then debug drops.
    drive_cycle(1'b0, 1'b1, 12'h004, 1'b1, 4'h0, 12'h006, '0, 1'b1, 1'b0);
    check_cnt("cnt_one_denial", 32'd1);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check_cnt("cnt_after_drop", 32'd0);

    // Reset while a fetch read is in flight.
    drive_cycle(1'b0, 1'b1, 12'h001, 1'b1, 4'h0, 12'h002, '0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 12'h002, 1'b1, 4'hF, 12'h009, 32'h5, 1'b0, 1'b0);
    check_cnt("cnt_after_midreset", 32'd0);
    idle();
    drive_cycle(1'b0, 1'b1, 12'h000, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
